cdb_arbiter: RTL
================

CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 SHALL have parameter NUM_FU, default 3, meaning the number of functional-unit requesters (ALU0, ALU1, MEM).
REQ-002 SHALL have parameter TAG_W, default $clog2(ROB_SIZE), meaning the ROB tag width.
REQ-003 SHALL have port clock, input, 1, meaning the single clock; all state updates on posedge.
REQ-004 SHALL have port reset, input, 1, meaning synchronous active-high reset.
REQ-005 SHALL have port flush, input, 1, meaning mispredict squash from the ROB.
REQ-006 SHALL have port fu_valid, input, NUM_FU, meaning per-FU result valid.
REQ-007 SHALL have port fu_tag, input, NUM_FU x TAG_W, meaning per-FU ROB tag.
REQ-008 SHALL have port fu_value, input, NUM_FU x XLEN, meaning per-FU result value.
REQ-009 SHALL have port fu_take_branch, input, NUM_FU, meaning per-FU resolved-taken flag.
REQ-010 SHALL have port fu_ready, output, NUM_FU, meaning the FU result is accepted this cycle.
REQ-011 SHALL have port cdb_packet, output, CDB_PACKET, meaning the registered broadcast: valid, Tag, Value, take_branch.

Function
REQ-012 SHALL hold one result buffer per FU (hold_valid/tag/value/take_branch).
REQ-013 SHALL drive fu_ready[i] = !hold_valid[i] || grant[i], combinationally; pass-through into a buffer being drained is allowed.
REQ-014 SHALL capture the fu_* fields into buffer i at the clock edge when fu_valid[i] && fu_ready[i].
REQ-015 SHALL compute grant as one-hot among hold_valid only; raw fu_valid SHALL never be granted directly.
REQ-016 SHALL arbitrate round-robin from pointer rr_ptr: the first valid index at or after rr_ptr, modulo NUM_FU, wins.
REQ-017 SHALL set rr_ptr to (winner+1) mod NUM_FU after a grant, and leave it unchanged when there is no grant.
REQ-018 SHALL register the winner into cdb_packet with valid=1; with no grant, cdb_packet.valid SHALL be 0 next cycle and the other fields SHALL hold.
REQ-019 SHALL give a minimum latency of 2 edges from fu_valid accept to cdb_packet.valid: the accept edge, then the grant edge.
REQ-020 SHALL, when buffer i is granted and re-filled in the same cycle, take the new result and leave hold_valid[i]=1.
REQ-021 SHALL, on flush, clear all hold_valid and cdb_packet.valid at the next edge, override same-cycle accepts, keep fu_ready=0 that cycle, and preserve rr_ptr.
REQ-022 SHALL, while any buffer holds a take_branch=1 result, give that buffer priority over round-robin (lowest index first); rr_ptr SHALL still update per REQ-017.
REQ-023 SHALL never broadcast two results in one cycle, nor drop or duplicate an accepted result absent flush.

Reset
REQ-024 SHALL clear, on reset, hold_valid, every cdb_packet field, and rr_ptr (all to 0); fu_ready SHALL read all-ones the cycle after reset.
REQ-025 SHALL give reset priority over flush and accepts, and a reset mid-traffic SHALL discard every buffered result.

Configuration
REQ-026 SHALL, with CDB_ARB_STATS_EN defined, add outputs grant_count[NUM_FU] (32 bits each, +1 per grant) and conflict_cycles (32 bits, +1 per cycle with >=2 hold_valid), both zeroed on reset, wrapping modulo 2^32, and unaffected by flush.
REQ-027 SHALL, without CDB_ARB_STATS_EN, have neither those ports nor any counter logic.

Structure
REQ-028 SHALL take CDB_PACKET, XLEN and ROB_SIZE from the shared sys_defs package, and a new FU_RESULT typedef (valid, Tag, Value, take_branch) SHALL be added there.
REQ-029 SHALL put round-robin selection in one sub-module, rr_arbiter (inputs req and ptr; output one-hot gnt), with no state of its own.

Verification
REQ-030 SHALL cover: reset, then fu_valid=3'b001, tag 5, value 0x10 -> fu_ready=111; cdb valid, Tag 5, Value 0x10 exactly 2 edges later.
REQ-031 SHALL cover: all three FUs valid at once with tags 1,2,3 and rr_ptr=0 -> cdb Tags 1,2,3 on consecutive cycles; fu_ready[1] and fu_ready[2] low until each buffer drains.
REQ-032 SHALL cover: a continuous stream from FU0 and FU2 -> strictly alternating grants, neither starved, and 1 result per cycle after warm-up.
REQ-033 SHALL cover: FU1 holds take_branch=1 while FU0 and FU2 are pending -> FU1 broadcast first, with cdb take_branch=1.
REQ-034 SHALL cover: flush asserted with all buffers full and fu_valid high -> next cycle cdb valid=0, all hold empty, fu_ready=111, rr_ptr unchanged.
REQ-035 SHALL cover: reset during traffic with CDB_ARB_STATS_EN defined -> counters 0, no stale broadcast; then 4 grants to FU0 -> grant_count[0]=4.

Source files
------------

// File: rtl/sys_defs.sv
// Shared processor definitions: data width, ROB sizing, the CDB broadcast
// packet and the functional-unit result record.
package sys_defs;

  localparam int XLEN      = 32;
  localparam int ROB_SIZE  = 16;
  localparam int ROB_TAG_W = $clog2(ROB_SIZE);

  typedef struct packed {
    logic                 valid;
    logic [ROB_TAG_W-1:0] Tag;
    logic [XLEN-1:0]      Value;
    logic                 take_branch;
  } CDB_PACKET;

  typedef struct packed {
    logic                 valid;
    logic [ROB_TAG_W-1:0] Tag;
    logic [XLEN-1:0]      Value;
    logic                 take_branch;
  } FU_RESULT;

endpackage

// File: rtl/cdb_arbiter_rr.sv
// Stateless round-robin selector: grants the first requester at or after
// ptr, wrapping modulo N. The pointer register lives in the caller.
module rr_arbiter #(
  parameter int N     = 3,
  parameter int PTR_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     gnt
);

  // Scan N positions starting at ptr; the first active request wins.
  always_comb begin
    logic found;
    int   idx;
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx      = (int'(ptr) + k) % N;
      gnt[idx] = gnt[idx] | (req[idx] & ~found);
      found    = found | req[idx];
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter. Each functional unit deposits its result into a
// private one-entry buffer; one buffered result per cycle is broadcast on the
// registered CDB. Taken-branch results jump the round-robin queue so that
// mispredict recovery starts as early as possible.
// Optional build macro: CDB_ARB_STATS_EN adds grant and conflict counters.
module cdb_arbiter
  import sys_defs::*;
#(
  parameter int NUM_FU = 3,
  parameter int TAG_W  = $clog2(ROB_SIZE)
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          flush,
  input  logic [NUM_FU-1:0]             fu_valid,
  input  logic [NUM_FU-1:0][TAG_W-1:0]  fu_tag,
  input  logic [NUM_FU-1:0][XLEN-1:0]   fu_value,
  input  logic [NUM_FU-1:0]             fu_take_branch,
  output logic [NUM_FU-1:0]             fu_ready,
  output CDB_PACKET                     cdb_packet
`ifdef CDB_ARB_STATS_EN
  ,
  output logic [NUM_FU-1:0][31:0]       grant_count,
  output logic [31:0]                   conflict_cycles
`endif
);

  localparam int PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

  FU_RESULT          hold [NUM_FU];
  logic [NUM_FU-1:0] hold_valid;
  logic [NUM_FU-1:0] hold_br;
  logic [NUM_FU-1:0] rr_gnt;
  logic [NUM_FU-1:0] br_gnt;
  logic [NUM_FU-1:0] grant;
  logic              any_grant;
  logic [PTR_W-1:0]  rr_ptr;
  logic [PTR_W-1:0]  win_idx;
  logic [PTR_W-1:0]  next_ptr;

  // Flatten buffer status bits for the selectors.
  always_comb begin
    hold_valid = '0;
    hold_br    = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      hold_valid[i] = hold[i].valid;
      hold_br[i]    = hold[i].valid & hold[i].take_branch;
    end
  end

  rr_arbiter #(
    .N     (NUM_FU),
    .PTR_W (PTR_W)
  ) u_rr (
    .req (hold_valid),
    .ptr (rr_ptr),
    .gnt (rr_gnt)
  );

  // Taken-branch results win outright, lowest index first.
  always_comb begin
    logic found;
    br_gnt = '0;
    found  = 1'b0;
    for (int i = 0; i < NUM_FU; i++) begin
      br_gnt[i] = hold_br[i] & ~found;
      found     = found | hold_br[i];
    end
  end

  // Final one-hot grant, its index, and the pointer that follows it.
  always_comb begin
    grant     = (|br_gnt) ? br_gnt : rr_gnt;
    any_grant = |grant;
    win_idx   = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      win_idx = grant[i] ? PTR_W'(i) : win_idx;
    end
    if (int'(win_idx) == NUM_FU - 1) begin
      next_ptr = '0;
    end else begin
      next_ptr = win_idx + 1'b1;
    end
  end

  // A buffer can accept when empty or when it is being drained this cycle;
  // nothing is accepted during a squash.
  always_comb begin
    if (flush) begin
      fu_ready = '0;
    end else begin
      fu_ready = ~hold_valid | grant;
    end
  end

  // Result buffers, round-robin pointer and the registered broadcast.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_FU; i++) begin
        hold[i] <= '0;
      end
      cdb_packet <= '0;
      rr_ptr     <= '0;
    end else if (flush) begin
      for (int i = 0; i < NUM_FU; i++) begin
        hold[i].valid <= 1'b0;
      end
      cdb_packet.valid <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_FU; i++) begin
        if (fu_valid[i] && fu_ready[i]) begin
          hold[i].valid       <= 1'b1;
          hold[i].Tag         <= fu_tag[i];
          hold[i].Value       <= fu_value[i];
          hold[i].take_branch <= fu_take_branch[i];
        end else if (grant[i]) begin
          hold[i].valid <= 1'b0;
        end
      end
      if (any_grant) begin
        cdb_packet.valid       <= 1'b1;
        cdb_packet.Tag         <= hold[win_idx].Tag;
        cdb_packet.Value       <= hold[win_idx].Value;
        cdb_packet.take_branch <= hold[win_idx].take_branch;
        rr_ptr                 <= next_ptr;
      end else begin
        cdb_packet.valid <= 1'b0;
      end
    end
  end

`ifdef CDB_ARB_STATS_EN
  function automatic int count_ones(input logic [NUM_FU-1:0] v);
    int n;
    n = 0;
    for (int i = 0; i < NUM_FU; i++) begin
      n = n + int'(v[i]);
    end
    return n;
  endfunction

  // Broadcast and contention statistics; a squash does not disturb them.
  always_ff @(posedge clock) begin
    if (reset) begin
      grant_count     <= '0;
      conflict_cycles <= 32'd0;
    end else begin
      if (any_grant && !flush) begin
        grant_count[win_idx] <= grant_count[win_idx] + 32'd1;
      end
      if (count_ones(hold_valid) >= 2) begin
        conflict_cycles <= conflict_cycles + 32'd1;
      end
    end
  end
`endif

endmodule
